// File: rtl/touch_feedback_driver_if.sv
// Requester-side bundle for touch_feedback_driver: trigger/count in, status and buzzer drive out.
// The abort input exists only when TOUCH_FEEDBACK_ABORT_EN is defined.
interface touch_feedback_driver_if;
   logic       trigger;
   logic [3:0] beep_count;
   logic       busy;
   logic       done;
   logic       buzzer;
`ifdef TOUCH_FEEDBACK_ABORT_EN
   logic       abort;

   modport master (output trigger, beep_count, abort, input busy, done, buzzer);
   modport slave  (input trigger, beep_count, abort, output busy, done, buzzer);
`else
   modport master (output trigger, beep_count, input busy, done, buzzer);
   modport slave  (input trigger, beep_count, output busy, done, buzzer);
`endif
endinterface

// File: rtl/touch_feedback_driver.sv
// Plays N square-wave beeps separated by silent gaps on a piezo buzzer, reporting busy/done.
// Optional feature macro: TOUCH_FEEDBACK_ABORT_EN adds an abort input that cancels a running sequence.
module touch_feedback_driver #(
   parameter int TONE_DIV   = 25000,
   parameter int ON_CYCLES  = 10000000,
   parameter int OFF_CYCLES = 10000000,
   parameter int CNT_W      = 24
) (
   input  logic                     clk,
   input  logic                     rst,
   touch_feedback_driver_if.slave   fb_if
);
   typedef enum logic [1:0] {IDLE, TONE, GAP} state_t;

   localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(TONE_DIV - 1);
   localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);
   localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_CYCLES - 1);

   state_t           state_q, state_d;
   logic [3:0]       rem_q, rem_d;
   logic [CNT_W-1:0] dur_q, dur_d;
   logic [CNT_W-1:0] div_q, div_d;
   logic             buz_q, buz_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             abort_req;

`ifdef TOUCH_FEEDBACK_ABORT_EN
   assign abort_req = fb_if.abort;
`else
   assign abort_req = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      dur_d   = dur_q;
      div_d   = div_q;
      buz_d   = buz_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            buz_d = 1'b0;
            // abort held in IDLE also swallows a simultaneous trigger
            if (fb_if.trigger && fb_if.beep_count != 4'd0 && !abort_req) begin
               state_d = TONE;
               rem_d   = fb_if.beep_count;
               dur_d   = '0;
               div_d   = '0;
               buz_d   = 1'b1;
            end
         end
         TONE: begin
            if (dur_q == ON_LAST) begin
               dur_d = '0;
               buz_d = 1'b0;
               if (rem_q > 4'd1) begin
                  rem_d   = rem_q - 4'd1;
                  state_d = GAP;
               end else begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end else begin
               dur_d = dur_q + 1'b1;
               if (div_q == DIV_LAST) begin
                  div_d = '0;
                  buz_d = ~buz_q;
               end else begin
                  div_d = div_q + 1'b1;
               end
            end
         end
         GAP: begin
            buz_d = 1'b0;
            if (dur_q == OFF_LAST) begin
               state_d = TONE;
               dur_d   = '0;
               div_d   = '0;
               buz_d   = 1'b1;
            end else begin
               dur_d = dur_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      if (abort_req && state_q != IDLE) begin
         state_d = IDLE;
         rem_d   = '0;
         dur_d   = '0;
         div_d   = '0;
         buz_d   = 1'b0;
         done_d  = 1'b0;
      end
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         rem_q   <= '0;
         dur_q   <= '0;
         div_q   <= '0;
         buz_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         rem_q   <= rem_d;
         dur_q   <= dur_d;
         div_q   <= div_d;
         buz_q   <= buz_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign fb_if.busy   = busy_q;
   assign fb_if.done   = done_q;
   assign fb_if.buzzer = buz_q;
endmodule

// File: tb/tb_touch_feedback_driver.sv
// Randomized plus directed bench for touch_feedback_driver against a timeline-based reference model.
module tb_touch_feedback_driver;
   localparam int TONE_DIV   = 2;
   localparam int ON_CYCLES  = 8;
   localparam int OFF_CYCLES = 4;
`ifdef TOUCH_FEEDBACK_ABORT_EN
   localparam bit ABORT_EN = 1'b1;
`else
   localparam bit ABORT_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   logic ab;
   int   n_cmp = 0;
   int   n_bad = 0;

   touch_feedback_driver_if fb_if ();
`ifdef TOUCH_FEEDBACK_ABORT_EN
   assign fb_if.abort = ab;
`endif

   touch_feedback_driver #(
      .TONE_DIV(TONE_DIV), .ON_CYCLES(ON_CYCLES), .OFF_CYCLES(OFF_CYCLES), .CNT_W(24)
   ) dut (
      .clk(clk), .rst(rst), .fb_if(fb_if)
   );

   always #5 clk = ~clk;

   // model: sequence is a timeline indexed by k cycles after the accept edge
   bit in_seq = 1'b0;
   int k = 0;
   int n = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   task automatic expect_now(output bit e_busy, output bit e_done, output bit e_buz);
      int total, j;
      e_busy = 1'b0; e_done = 1'b0; e_buz = 1'b0;
      if (in_seq) begin
         total = ON_CYCLES * n + OFF_CYCLES * (n - 1);
         if (k >= 1 && k <= total) begin
            e_busy = 1'b1;
            j = (k - 1) % (ON_CYCLES + OFF_CYCLES);
            if (j < ON_CYCLES) e_buz = ((j / TONE_DIV) % 2) == 0;
         end
         e_done = (k == total + 1);
      end
   endtask

   // one clock cycle: drive, sample mid-cycle, advance model at the edge
   task automatic cyc(input bit r, input bit trig, input logic [3:0] bc, input bit a);
      bit eb, ed, ez;
      int total;
      rst = r; fb_if.trigger = trig; fb_if.beep_count = bc; ab = a;
      @(negedge clk);
      expect_now(eb, ed, ez);
      chk("busy",   {31'd0, fb_if.busy},   {31'd0, eb});
      chk("done",   {31'd0, fb_if.done},   {31'd0, ed});
      chk("buzzer", {31'd0, fb_if.buzzer}, {31'd0, ez});
      if (r) in_seq = 1'b0;
      else if (ABORT_EN && a && eb) in_seq = 1'b0;
      else if (!eb && trig && bc != 4'd0 && !(ABORT_EN && a)) begin
         in_seq = 1'b1; n = bc; k = 1;
      end else if (in_seq) begin
         total = ON_CYCLES * n + OFF_CYCLES * (n - 1);
         k++;
         if (k > total + 1) in_seq = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int cnt);
      for (int i = 0; i < cnt; i++) cyc(1'b0, 1'b0, 4'd0, 1'b0);
   endtask

   initial begin
      rst = 1'b1; fb_if.trigger = 1'b0; fb_if.beep_count = 4'd0; ab = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      idle(3);
      // single beep
      cyc(1'b0, 1'b1, 4'd1, 1'b0);
      idle(12);
      // three beeps with a re-trigger in the middle of the first tone
      cyc(1'b0, 1'b1, 4'd3, 1'b0);
      idle(4);
      cyc(1'b0, 1'b1, 4'd2, 1'b0);
      idle(35);
      // zero count is ignored
      for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, 4'd0, 1'b0);
      // trigger held high: back-to-back single beeps
      for (int i = 0; i < 20; i++) cyc(1'b0, 1'b1, 4'd1, 1'b0);
      idle(10);
      // reset during the second tone of a 3-beep sequence, then replay
      cyc(1'b0, 1'b1, 4'd3, 1'b0);
      idle(13);
      cyc(1'b1, 1'b0, 4'd0, 1'b0);
      idle(20);
      cyc(1'b0, 1'b1, 4'd3, 1'b0);
      idle(36);
      // abort in a gap of a 2-beep sequence, then abort with trigger while idle
      cyc(1'b0, 1'b1, 4'd2, 1'b0);
      idle(9);
      cyc(1'b0, 1'b0, 4'd0, 1'b1);
      idle(20);
      cyc(1'b0, 1'b1, 4'd2, 1'b1);
      idle(30);
      // random traffic
      for (int i = 0; i < 4000; i++) begin
         cyc(($urandom_range(0, 299) == 0),
             ($urandom_range(0, 19) == 0),
             4'($urandom_range(0, 4)),
             ($urandom_range(0, 99) == 0));
      end
      idle(5);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
